// File: rtl/regfile_sb_pkg.sv
// Shared sizing constants for the register file and its write scoreboard.
package regfile_sb_pkg;

  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned ADDR_WIDTH   = 5;
  localparam int unsigned SB_CNT_WIDTH = 2;

endpackage

// File: rtl/regfile_sb_sb_counter.sv
// Per-register pending-write counter: one issue increment and up to two releases per cycle.
// Out-of-range results clamp to 0 or max and raise a one-cycle err pulse.
module sb_counter
  import regfile_sb_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = SB_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec1,
  input  logic                 dec2,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 nonzero,
  output logic                 full,
  output logic                 err
);

  localparam int unsigned SumWidth = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  logic [SumWidth-1:0]  up;
  logic [SumWidth-1:0]  down;
  logic [SumWidth-1:0]  diff;
  logic [CNT_WIDTH-1:0] count_d;

  // One spare bit so both the +1 and the -2 extremes are representable before clamping.
  always_comb begin
    up      = {1'b0, count} + SumWidth'(inc);
    down    = SumWidth'(dec1) + SumWidth'(dec2);
    diff    = up - down;
    count_d = diff[CNT_WIDTH-1:0];
    err     = 1'b0;
    if (up < down) begin
      count_d = '0;
      err     = 1'b1;
    end else if (diff > {1'b0, CntMax}) begin
      count_d = CntMax;
      err     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

  assign nonzero = |count;
  assign full    = &count;

endmodule

// File: rtl/regfile_sb.sv
// Architectural register file with an in-flight write scoreboard and decode stall.
// Define REGFILE_SB_BYPASS_EN to forward the write-back data to the read ports.
module regfile_sb #(
  parameter int unsigned DATA_WIDTH = regfile_sb_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = regfile_sb_pkg::ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH  = regfile_sb_pkg::SB_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_wen,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  wb_kill,
  input  logic [ADDR_WIDTH-1:0] wb_kill_rd,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  issue_valid,
  input  logic                  issue_wen,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  stall,
  output logic                  sb_err
);

  import regfile_sb_pkg::*;

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NumRegs];

  logic [NumRegs-1:0][CNT_WIDTH-1:0] cnt;
  logic [NumRegs-1:0] cnt_nz;
  logic [NumRegs-1:0] cnt_full;
  logic [NumRegs-1:0] cnt_err;

  logic match1, match2;
  logic byp1, byp2;
  logic haz1, haz2, waw;
  logic sb_err_q;

  // Entry 0 is cleared by reset and never written, so it always reads back zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_wen && (wb_rd != '0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  assign cnt[0]      = '0;
  assign cnt_nz[0]   = 1'b0;
  assign cnt_full[0] = 1'b0;
  assign cnt_err[0]  = 1'b0;

  for (genvar r = 1; r < NumRegs; r++) begin : g_cnt
    logic inc_r, dec1_r, dec2_r;

    assign inc_r  = issue_valid && issue_wen && !stall && (issue_rd == ADDR_WIDTH'(r));
    assign dec1_r = wb_wen && (wb_rd == ADDR_WIDTH'(r));
    assign dec2_r = wb_kill && (wb_kill_rd == ADDR_WIDTH'(r));

    sb_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (inc_r),
      .dec1   (dec1_r),
      .dec2   (dec2_r),
      .count  (cnt[r]),
      .nonzero(cnt_nz[r]),
      .full   (cnt_full[r]),
      .err    (cnt_err[r])
    );
  end

`ifdef REGFILE_SB_BYPASS_EN
  assign match1 = wb_wen && (wb_rd == rs1_addr) && (rs1_addr != '0);
  assign match2 = wb_wen && (wb_rd == rs2_addr) && (rs2_addr != '0);
  // Only the last outstanding write may be forwarded; older producers still hold decode.
  assign byp1   = match1 && (cnt[rs1_addr] == CNT_WIDTH'(1));
  assign byp2   = match2 && (cnt[rs2_addr] == CNT_WIDTH'(1));
`else
  logic unused_cnt;
  assign match1     = 1'b0;
  assign match2     = 1'b0;
  assign byp1       = 1'b0;
  assign byp2       = 1'b0;
  assign unused_cnt = ^cnt;
`endif

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (match1) begin
      rs1_data = wb_data;
    end else if (rs1_addr != '0) begin
      rs1_data = regs[rs1_addr];
    end
    if (match2) begin
      rs2_data = wb_data;
    end else if (rs2_addr != '0) begin
      rs2_data = regs[rs2_addr];
    end
  end

  assign haz1  = rs1_used && (rs1_addr != '0) && cnt_nz[rs1_addr] && !byp1;
  assign haz2  = rs2_used && (rs2_addr != '0) && cnt_nz[rs2_addr] && !byp2;
  assign waw   = issue_wen && cnt_full[issue_rd];
  assign stall = issue_valid && (haz1 || haz2 || waw);

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err_q <= 1'b0;
    end else if (|cnt_err) begin
      sb_err_q <= 1'b1;
    end
  end

  assign sb_err = sb_err_q;

endmodule
